// File: rtl/div7_correct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div7_pkg
// Description : Shared constants and helpers for the divide-by-7 correction
//               stage: datapath widths, upstream latency default, the
//               shift-add reciprocal approximation and the remainder
//               thresholds used by the final refinement step.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
package div7_pkg;

  localparam int WIDTH   = 20;   // dividend / quotient width
  localparam int DIVISOR = 7;
  localparam int DIV_LAT = 8;    // upstream approximator latency
  localparam int REM_W   = WIDTH + 2;  // signed residual width

  // Remainder thresholds: multiples of the divisor.
  localparam int TH_7  = 7;
  localparam int TH_14 = 14;
  localparam int TH_21 = 21;
  localparam int TH_28 = 28;

  // x/7 ~= x/8 + x/64 + x/512 ; always an under-estimate for x >= 0.
  function automatic logic [REM_W-1:0] shift_sum(input logic [REM_W-1:0] x);
    return (x >> 3) + (x >> 6) + (x >> 9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div7_correct_if.sv
`default_nettype none
// ============================================================================
// Module      : div7_correct_if
// Description : Bundle of the data/valid signals around the divide-by-7
//               correction stage.
// Signals     : in_valid  - dividend valid (same cycle as upstream input)
//               dividend  - dividend a
//               q_approx  - upstream approximate quotient, DIV_LAT later
//               out_valid - q_out/r_out valid
//               q_out     - floor(a/7)
//               r_out     - a mod 7
//               err       - sticky range-violation flag
// Modports    : master - drives dividend/q_approx, observes results
//               slave  - the correction stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface div7_correct_if #(
  parameter int WIDTH = div7_pkg::WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] q_approx;
  logic             out_valid;
  logic [WIDTH-1:0] q_out;
  logic [2:0]       r_out;
  logic             err;

  modport master (
    output in_valid, dividend, q_approx,
    input  out_valid, q_out, r_out, err
  );

  modport slave (
    input  in_valid, dividend, q_approx,
    output out_valid, q_out, r_out, err
  );
endinterface
`default_nettype wire

// File: rtl/div7_correct_dly_line.sv
`default_nettype none
// ============================================================================
// Module      : dly_line
// Description : DEPTH-stage valid/data delay chain. The valid bit always
//               shifts; each data stage only loads when the valid feeding it
//               is set, so idle slots hold their previous contents.
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_data   - chain input
//               out_valid/out_data - chain output, DEPTH cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module dly_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_data[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/div7_correct.sv
`default_nettype none
// ============================================================================
// Module      : div7_correct
// Description : Turns the upstream shift-add approximate quotient into the
//               exact floor(a/7) and a mod 7. The dividend is delayed to
//               meet its approximate quotient, then refined in three stages:
//                 S1: r0 = a - 7*q_approx
//                 S2: d = shift_sum(|r0|), q1 = q_approx + d, r1 = r0 - 7*d
//                 S3: k = floor(r1/7) (0..3), q = q1 + k, r = r1 - 7*k
//               A sticky err flag records residuals outside the range a
//               correct upstream can produce (r0 < 0 or r1 >= 28).
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - div7_correct_if slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module div7_correct #(
  parameter int WIDTH   = div7_pkg::WIDTH,
  parameter int DIV_LAT = div7_pkg::DIV_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  div7_correct_if.slave bus
);
  import div7_pkg::*;

  localparam int SW = WIDTH + 2;

  localparam logic signed [SW-1:0] C_TH7  = SW'(TH_7);
  localparam logic signed [SW-1:0] C_TH14 = SW'(TH_14);
  localparam logic signed [SW-1:0] C_TH21 = SW'(TH_21);
  localparam logic signed [SW-1:0] C_TH28 = SW'(TH_28);

  // --------------------------------------------------------------------------
  // Alignment: dividend travels alongside the upstream divider
  // --------------------------------------------------------------------------
  logic             w_dly_vld;
  logic [WIDTH-1:0] w_dly_a;

  dly_line #(
    .DEPTH (DIV_LAT),
    .W     (WIDTH)
  ) u_dly_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_data   (bus.dividend),
    .out_valid (w_dly_vld),
    .out_data  (w_dly_a)
  );

  // --------------------------------------------------------------------------
  // S1: first residual
  // --------------------------------------------------------------------------
  logic signed [SW-1:0] w_a_ext;
  logic signed [SW-1:0] w_q_ext;
  logic signed [SW-1:0] w_r0;

  assign w_a_ext = $signed({2'b00, w_dly_a});
  assign w_q_ext = $signed({2'b00, bus.q_approx});
  assign w_r0    = w_a_ext - (w_q_ext <<< 3) + w_q_ext;

  logic                 r_v1;
  logic [WIDTH-1:0]     r_qa;
  logic signed [SW-1:0] r_r0;
  logic                 r_bad1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_qa   <= '0;
      r_r0   <= '0;
      r_bad1 <= 1'b0;
    end else begin
      r_v1 <= w_dly_vld;
      if (w_dly_vld) begin
        r_qa   <= bus.q_approx;
        r_r0   <= w_r0;
        r_bad1 <= w_r0[SW-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2: second approximation pass on the residual
  // --------------------------------------------------------------------------
  logic signed [SW-1:0] w_mag;
  logic [SW-1:0]        w_d;
  logic signed [SW-1:0] w_d_s;
  logic signed [SW-1:0] w_r1;
  logic [WIDTH-1:0]     w_q1;

  // A negative r0 is already an error; its magnitude just keeps d bounded.
  assign w_mag = r_r0[SW-1] ? -r_r0 : r_r0;
  assign w_d   = shift_sum(w_mag);
  assign w_d_s = $signed(w_d);
  assign w_r1  = r_r0 - (w_d_s <<< 3) + w_d_s;
  assign w_q1  = r_qa + w_d[WIDTH-1:0];

  logic                 r_v2;
  logic [WIDTH-1:0]     r_q1;
  logic signed [SW-1:0] r_r1;
  logic                 r_bad2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_q1   <= '0;
      r_r1   <= '0;
      r_bad2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_q1   <= w_q1;
        r_r1   <= w_r1;
        r_bad2 <= r_bad1 | (w_r1 >= C_TH28);
      end
    end
  end

  // --------------------------------------------------------------------------
  // S3: final small correction, k in 0..3
  // --------------------------------------------------------------------------
  logic [1:0]       w_k;
  logic [WIDTH-1:0] w_q_fin;
  logic [2:0]       w_r_fin;

  always_comb begin
    w_k = 2'd0;
    if (r_r1 >= C_TH21) begin
      w_k = 2'd3;
    end else if (r_r1 >= C_TH14) begin
      w_k = 2'd2;
    end else if (r_r1 >= C_TH7) begin
      w_k = 2'd1;
    end
  end

  assign w_q_fin = r_q1 + {{(WIDTH-2){1'b0}}, w_k};
  // The remainder fits in 3 bits, and -7k == +k modulo 8, so only the low
  // bits of r1 are needed here.
  assign w_r_fin = r_r1[2:0] + {1'b0, w_k};

  logic             r_out_vld;
  logic [WIDTH-1:0] r_q_out;
  logic [2:0]       r_r_out;
  logic             r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_q_out   <= '0;
      r_r_out   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_out_vld <= r_v2;
      if (r_v2) begin
        r_q_out <= w_q_fin;
        r_r_out <= w_r_fin;
      end
      r_err <= r_err | (r_v2 & r_bad2);
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.q_out     = r_q_out;
  assign bus.r_out     = r_r_out;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_div7_correct.sv
`default_nettype none
// ============================================================================
// Module      : tb_div7_correct
// Description : Self-checking bench for div7_correct. A driver issues
//               dividends, models the upstream approximator and queues the
//               exact quotient/remainder; a monitor compares each result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div7_correct;

  localparam int W   = div7_pkg::WIDTH;
  localparam int LAT = div7_pkg::DIV_LAT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div7_correct_if bus ();

  div7_correct #(
    .WIDTH   (W),
    .DIV_LAT (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int q;
    int r;
    bit err;
    bit dc;     // quotient/remainder not defined for this item
    int issue;  // cycle count when issued
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   hist[LAT];
  bit   err_model  = 1'b0;
  bit   hold_known = 1'b1;
  int   hold_q     = 0;
  int   hold_r     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream divider behaviour.
  function automatic int approx(input int a);
    return (a >> 3) + (a >> 6) + (a >> 9);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input int a, input bit bad);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.dividend = W'(a);
    bus.q_approx = W'(hist[LAT-1]);
    for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bad ? (a / 7 + 5) : approx(a);
    if (v) begin
      if (bad) err_model = 1'b1;
      e.q     = a / 7;
      e.r     = a % 7;
      e.err   = err_model;
      e.dc    = bad;
      e.issue = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_q_out", int'(bus.q_out), 0);
    chk("rst_r_out", int'(bus.r_out), 0);
    chk("rst_err", int'(bus.err), 0);
    sb.delete();
    err_model  = 1'b0;
    hold_known = 1'b1;
    hold_q     = 0;
    hold_r     = 0;
    for (int i = 0; i < LAT; i++) hist[i] = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.issue, LAT + 3);
          chk("err", int'(bus.err), int'(e.err));
          if (!e.dc) begin
            chk("q_out", int'(bus.q_out), e.q);
            chk("r_out", int'(bus.r_out), e.r);
            hold_known = 1'b1;
            hold_q     = e.q;
            hold_r     = e.r;
          end else begin
            hold_known = 1'b0;
          end
        end
      end else if (hold_known) begin
        chk("hold_q", int'(bus.q_out), hold_q);
        chk("hold_r", int'(bus.r_out), hold_r);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.q_approx = '0;
    for (int i = 0; i < LAT; i++) hist[i] = 0;

    // Power-on reset state
    repeat (2) @(negedge clk);
    #1;
    chk("init_out_valid", int'(bus.out_valid), 0);
    chk("init_q_out", int'(bus.q_out), 0);
    chk("init_r_out", int'(bus.r_out), 0);
    chk("init_err", int'(bus.err), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Single pulse
    drive(1'b1, 7168, 1'b0);
    idle(LAT + 5);

    // Bounds back to back
    drive(1'b1, 0, 1'b0);
    drive(1'b1, 6, 1'b0);
    drive(1'b1, 1048575, 1'b0);
    idle(LAT + 5);

    // Valid pattern 1,0,1,1,0
    drive(1'b1, 328752, 1'b0);
    drive(1'b0, 0, 1'b0);
    drive(1'b1, 1483, 1'b0);
    drive(1'b1, 622592, 1'b0);
    drive(1'b0, 0, 1'b0);
    idle(LAT + 5);

    // Reset with four items spread through the pipe
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 200, 1'b0);
    drive(1'b1, 300, 1'b0);
    drive(1'b1, 400, 1'b0);
    idle(LAT - 2);
    pulse_reset();
    drive(1'b1, 12345, 1'b0);
    idle(LAT + 5);

    // Random sweep
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, (1 << 20) - 1)), 1'b0);
    end
    idle(LAT + 5);

    // Corrupted upstream quotient, then good items with err held
    drive(1'b1, 700, 1'b1);
    drive(1'b1, 7168, 1'b0);
    drive(1'b1, 50, 1'b0);
    idle(LAT + 5);
    pulse_reset();
    drive(1'b1, 99, 1'b0);
    idle(LAT + 5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
